// File: rtl/cacheline_adapter.sv
// Cache-line <-> memory burst adapter: splits a line write into beats and assembles read beats into a line.
// Optional CACHELINE_ADAPTER_PERF_EN adds read/write completion counters (rd_count, wr_count).
module cacheline_adapter #(
  parameter int s_offset    = 5,
  parameter int burst_width = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [8*(2**s_offset)-1:0]   line_i,
  input  logic [31:0]                  address_i,
  input  logic                         read_i,
  input  logic                         write_i,
  output logic [8*(2**s_offset)-1:0]   line_o,
  output logic                         resp_o,
  input  logic [burst_width-1:0]       burst_i,
  input  logic                         resp_i,
  output logic [burst_width-1:0]       burst_o,
  output logic [31:0]                  address_o,
  output logic                         read_o,
  output logic                         write_o
`ifdef CACHELINE_ADAPTER_PERF_EN
  ,
  output logic [31:0]                  rd_count,
  output logic [31:0]                  wr_count
`endif
);

  localparam int line_width = 8 * (2**s_offset);
  localparam int beats      = line_width / burst_width;
  localparam int cnt_w      = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [cnt_w-1:0]       cnt;
  logic [31-s_offset:0]   addr_r;
  logic [line_width-1:0]  line_r;
  logic                   unused_addr_bits;

  // Byte-offset bits never reach memory; the address is line-aligned.
  assign unused_addr_bits = ^address_i[s_offset-1:0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (write_i)     state_next = WRITE;
        else if (read_i) state_next = READ;
        else             state_next = IDLE;
      end
      READ, WRITE: begin
        if (resp_i && (cnt == last_beat)) state_next = DONE;
        else                              state_next = state;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_r <= '0;
      line_r <= '0;
      line_o <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (write_i) begin
            addr_r <= address_i[31:s_offset];
            line_r <= line_i;
            cnt    <= '0;
          end else if (read_i) begin
            addr_r <= address_i[31:s_offset];
            cnt    <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[cnt*burst_width +: burst_width] <= burst_i;
            cnt <= cnt + cnt_w'(1);
          end
        end
        WRITE: begin
          if (resp_i) cnt <= cnt + cnt_w'(1);
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state register so they stay high through stalls.
  assign read_o    = (state == READ);
  assign write_o   = (state == WRITE);
  assign resp_o    = (state == DONE);
  assign burst_o   = line_r[cnt*burst_width +: burst_width];
  assign address_o = {addr_r, {s_offset{1'b0}}};

`ifdef CACHELINE_ADAPTER_PERF_EN
  logic was_read;

  // Remember which kind of burst is in flight so DONE can bump the right counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      was_read <= 1'b0;
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else begin
      if (state == IDLE && (read_i || write_i)) was_read <= ~write_i;
      if (state == DONE) begin
        if (was_read) rd_count <= rd_count + 32'd1;
        else          wr_count <= wr_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter; inputs change and outputs are sampled on the falling edge.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic         resp_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
`ifdef CACHELINE_ADAPTER_PERF_EN
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;
`endif

  int checks = 0;
  int errors = 0;

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o)
`ifdef CACHELINE_ADAPTER_PERF_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Read burst with a resp_i pattern of n cycles; junk is driven on stall cycles.
  task automatic read_burst(input logic [31:0] addr, input logic [255:0] data,
                            input logic [15:0] pat, input int n);
    int k;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'b00000};
    @(negedge clk);
    read_i = 1'b1; address_i = addr; resp_i = 1'b0;
    k = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      read_i = 1'b0; address_i = 32'h0;
      check("rd_strobe", {255'd0, read_o}, 256'd1);
      check("rd_no_wstrobe", {255'd0, write_o}, 256'd0);
      check("rd_addr", {224'd0, address_o}, {224'd0, exp_addr});
      check("rd_resp_early", {255'd0, resp_o}, 256'd0);
      resp_i = pat[i];
      if (pat[i]) begin
        burst_i = data[k*64 +: 64];
        k++;
      end else begin
        burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end
    @(negedge clk);
    resp_i = 1'b0;
    check("rd_resp", {255'd0, resp_o}, 256'd1);
    check("rd_strobe_off", {255'd0, read_o}, 256'd0);
    check("rd_line", line_o, data);
    @(negedge clk);
    check("rd_resp_pulse", {255'd0, resp_o}, 256'd0);
    check("rd_line_hold", line_o, data);
  endtask

  // Write burst with resp_i tied high; 'both' also raises read_i for the whole burst.
  task automatic write_burst(input logic [31:0] addr, input logic [255:0] data, input logic both);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'b00000};
    @(negedge clk);
    write_i = 1'b1; read_i = both; address_i = addr; line_i = data; resp_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      write_i = 1'b0; line_i = 256'd0; address_i = 32'h0;
      check("wr_strobe", {255'd0, write_o}, 256'd1);
      check("wr_no_rstrobe", {255'd0, read_o}, 256'd0);
      check("wr_addr", {224'd0, address_o}, {224'd0, exp_addr});
      check("wr_beat", {192'd0, burst_o}, {192'd0, data[k*64 +: 64]});
      check("wr_resp_early", {255'd0, resp_o}, 256'd0);
      resp_i = 1'b1;
    end
    @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0;
    check("wr_resp", {255'd0, resp_o}, 256'd1);
    check("wr_strobe_off", {255'd0, write_o}, 256'd0);
    check("wr_no_rstrobe_done", {255'd0, read_o}, 256'd0);
    @(negedge clk);
    check("wr_resp_pulse", {255'd0, resp_o}, 256'd0);
    check("wr_idle_no_rstrobe", {255'd0, read_o}, 256'd0);
  endtask

  logic [255:0] rd_data, wr_data, stall_data, sim_data, last_data;

  initial begin
    rd_data    = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wr_data    = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                  64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    stall_data = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                  64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    sim_data   = {64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                  64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF};
    last_data  = {64'hCAFE_0003_CAFE_0003, 64'hCAFE_0002_CAFE_0002,
                  64'hCAFE_0001_CAFE_0001, 64'hCAFE_0000_CAFE_0000};

    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'h0; line_i = 256'd0; burst_i = 64'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_resp", {255'd0, resp_o}, 256'd0);
    check("rst_read", {255'd0, read_o}, 256'd0);
    check("rst_write", {255'd0, write_o}, 256'd0);
    check("rst_line", line_o, 256'd0);
    check("rst_addr", {224'd0, address_o}, 256'd0);
    rst = 1'b1;

    // resp_i in IDLE must not start anything or touch line_o
    resp_i = 1'b1; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    check("idle_resp_read", {255'd0, read_o}, 256'd0);
    check("idle_resp_done", {255'd0, resp_o}, 256'd0);
    check("idle_resp_line", line_o, 256'd0);
    resp_i = 1'b0;

    // Reset during beat 2 of a write aborts without resp_o
    write_i = 1'b1; address_i = 32'h0000_0040; line_i = wr_data;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      write_i = 1'b0; resp_i = 1'b1;
      check("abort_beat", {192'd0, burst_o}, {192'd0, wr_data[k*64 +: 64]});
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; resp_i = 1'b0;
    check("abort_write_off", {255'd0, write_o}, 256'd0);
    check("abort_no_resp", {255'd0, resp_o}, 256'd0);
    check("abort_addr", {224'd0, address_o}, 256'd0);
    @(negedge clk);
    check("abort_no_resp2", {255'd0, resp_o}, 256'd0);
    check("abort_write_off2", {255'd0, write_o}, 256'd0);

    read_burst(32'h0000_1234, rd_data, 16'h000F, 4);
    write_burst(32'h8000_00FF, wr_data, 1'b0);
    // resp_i pattern 1,0,0,1,0,1,1 (bit i = cycle i)
    read_burst(32'h0000_2000, stall_data, 16'b0000_0000_0110_1001, 7);
    write_burst(32'h1234_5678, sim_data, 1'b1);
    read_burst(32'hFFFF_FFFF, last_data, 16'h000F, 4);

`ifdef CACHELINE_ADAPTER_PERF_EN
    check("perf_rd", {224'd0, rd_count}, 256'd3);
    check("perf_wr", {224'd0, wr_count}, 256'd2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("perf_rd_rst", {224'd0, rd_count}, 256'd0);
    check("perf_wr_rst", {224'd0, wr_count}, 256'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 Parameter: s_offset, default 5, log2 of line size in bytes (line = 8*2**s_offset bits = 256).
REQ-002 Parameter: burst_width, default 64, memory beat width in bits; beats = line/burst_width = 4.
REQ-003 Reset is synchronous and active-low on rst; all logic is clocked on the rising edge of clk.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 line_i  input  256  line written by cache.
REQ-007 address_i  input  32  cache request byte address.
REQ-008 read_i  input  1  cache line read request.
REQ-009 write_i  input  1  cache line write request.
REQ-010 line_o  output  256  line returned to cache.
REQ-011 resp_o  output  1  transaction done, one-cycle pulse.
REQ-012 burst_i  input  64  memory read beat.
REQ-013 resp_i  input  1  memory beat valid/accepted.
REQ-014 burst_o  output  64  memory write beat.
REQ-015 address_o  output  32  line-aligned memory address.
REQ-016 read_o  output  1  memory burst read strobe.
REQ-017 write_o  output  1  memory burst write strobe.

Function
REQ-018 FSM states: IDLE, READ, WRITE, DONE; a 2-bit beat counter tracks beats 0..3.
REQ-019 IDLE: if write_i, latch address_i and line_i, clear counter, go WRITE; else if read_i, latch address_i, clear counter, go READ; write wins when both are high.
REQ-020 Requests are accepted only in IDLE; request levels in other states are ignored.
REQ-021 address_o = {latched address[31:s_offset], s_offset zeros}, held constant for the whole burst.
REQ-022 READ: read_o=1; each cycle with resp_i=1 stores burst_i into line_o bits [64k+63:64k] (k=counter) and increments counter; after the beat with k=3, go DONE.
REQ-023 WRITE: write_o=1, burst_o = latched line bits [64k+63:64k]; each resp_i=1 increments counter; after the beat with k=3, go DONE.
REQ-024 read_o and write_o stay continuously high across all four beats; stalls (resp_i=0) hold state, counter and outputs.
REQ-025 DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, then IDLE unconditionally.
REQ-026 line_o holds its last completed read value until the next READ beat 0 overwrites it.
REQ-027 Minimum latency: request accepted at edge N, beats at N+1..N+4 with resp_i tied high, resp_o high in cycle N+5.
REQ-028 resp_i in IDLE or DONE is ignored.

Reset
REQ-029 rst=0 at a clock edge: state IDLE, counter 0, line_o 0, latched address/line 0, resp_o/read_o/write_o 0.
REQ-030 Reset mid-burst aborts with no resp_o; strobes are low from the following cycle.

Configuration
REQ-031 Macro CACHELINE_ADAPTER_PERF_EN defined: add outputs rd_count and wr_count (32 bits each), incremented in DONE for read/write completions, wrapping at 2**32-1 to 0, cleared by reset.
REQ-032 Macro undefined: those ports and counters do not exist; all other behaviour is identical.

Verification
REQ-033 Read: read_i=1, address_i=0x0000_1234, resp_i high, beats 0x11..,0x22..,0x33..,0x44.. -> address_o=0x0000_1220, line_o={beat3,beat2,beat1,beat0}, resp_o pulses 5 cycles after acceptance.
REQ-034 Write: write_i=1, address_i=0x8000_00FF, line_i=256'hA..D -> address_o=0x8000_00E0, burst_o presents 64-bit slices 0..3 in order, one resp_o.
REQ-035 Stall: resp_i pattern 1,0,0,1,0,1,1 on read -> four beats captured in order, read_o held high throughout, resp_o after seventh cycle.
REQ-036 Simultaneous read_i=write_i=1 in IDLE -> WRITE burst only, read_o never asserted.
REQ-037 rst=0 during beat 2 of a write -> write_o low next cycle, no resp_o, next read_i accepted normally.
REQ-038 PERF_EN build: 3 reads + 2 writes -> rd_count=3, wr_count=2; reset -> both 0.
